// File: rtl/window_stream_buffer_if.sv
// Handshake bundle for window_stream_buffer: pixel stream in, flattened KxK window out.
// The master drives the pixel and window-ready signals; the slave (the buffer) drives the rest.
interface window_stream_buffer_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int K      = 5
);
    localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);

    logic                  i_pixel_valid;
    logic [DATA_W-1:0]     i_pixel;
    logic                  o_pixel_ready;
    logic [K*K*DATA_W-1:0] o_window;
    logic                  o_window_valid;
    logic                  i_window_ready;
    logic [CW-1:0]         o_row;
    logic [CW-1:0]         o_col;
    logic                  o_frame_done;
    logic                  o_empty;

    modport master (
        output i_pixel_valid, i_pixel, i_window_ready,
        input  o_pixel_ready, o_window, o_window_valid, o_row, o_col, o_frame_done, o_empty
    );

    modport slave (
        input  i_pixel_valid, i_pixel, i_window_ready,
        output o_pixel_ready, o_window, o_window_valid, o_row, o_col, o_frame_done, o_empty
    );
endinterface

// File: rtl/window_stream_buffer.sv
// Raster-order pixel stream to KxK sliding window, with valid/ready on both sides.
// K-1 line buffers feed a KxK shift array; only fully interior windows are emitted.
module window_stream_buffer #(
    parameter int  DATA_W = 8,
    parameter int  IMG_W  = 64,
    parameter int  IMG_H  = 64,
    parameter int  K      = 5,
    localparam int CW     = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_clear,
    window_stream_buffer_if.slave bus
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE     = CW'(K - 1);

    logic [CW-1:0]         pr_q, pc_q, pr_d, pc_d;
    logic [CW-1:0]         row_q, col_q;
    logic                  win_valid_q, done_q, empty_q;
    logic [K*K*DATA_W-1:0] window_q, window_d;
    logic [DATA_W-1:0]     lb_q  [K-1][IMG_W];
    logic [DATA_W-1:0]     win_q [K][K];
    logic [DATA_W-1:0]     win_d [K][K];
    logic                  ready, accept, emit, last;

    assign ready  = !i_clear && (!win_valid_q || bus.i_window_ready);
    assign accept = bus.i_pixel_valid && ready;
    assign last   = (pr_q == ROW_LAST) && (pc_q == COL_LAST);
    assign emit   = accept && (pr_q >= EDGE) && (pc_q >= EDGE);

    always_comb begin
        pc_d = pc_q + CW'(1);
        pr_d = pr_q;
        if (pc_q == COL_LAST) begin
            pc_d = '0;
            pr_d = (pr_q == ROW_LAST) ? '0 : pr_q + CW'(1);
        end
    end

    // Window shifts left one column; the new right column is the line-buffer column plus the live pixel.
    always_comb begin
        window_d = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int unsigned r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = lb_q[r][pc_q];
        end
        win_d[K-1][K-1] = bus.i_pixel;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                window_d[DATA_W*(r*K+c) +: DATA_W] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
            for (int unsigned j = 0; j < K - 2; j++) begin
                lb_q[j][pc_q] <= lb_q[j+1][pc_q];
            end
            lb_q[K-2][pc_q] <= bus.i_pixel;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pr_q        <= '0;
            pc_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            window_q    <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else if (i_clear) begin
            pr_q        <= '0;
            pc_q        <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            done_q <= emit && last;
            if (accept) begin
                pr_q    <= pr_d;
                pc_q    <= pc_d;
                empty_q <= last;
            end
            if (emit) begin
                window_q    <= window_d;
                win_valid_q <= 1'b1;
                row_q       <= pr_q - EDGE;
                col_q       <= pc_q - EDGE;
            end else if (bus.i_window_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_pixel_ready  = ready;
    assign bus.o_window       = window_q;
    assign bus.o_window_valid = win_valid_q;
    assign bus.o_row          = row_q;
    assign bus.o_col          = col_q;
    assign bus.o_frame_done   = done_q;
    assign bus.o_empty        = empty_q;
endmodule
